lc3_decode_stage: RTL
=====================

Name: lc3_decode_stage

Overview:
- Decode pipeline stage that drives the decode_out bus: IR, npc_out, E_control, W_control, Mem_Control.
- Each enabled cycle it takes one instruction word from instruction memory plus the next-PC from fetch, decodes the opcode into execute, writeback and memory control fields, and registers all results.
- Sits between the fetch stage and the execute stage. It is the DUT-side producer checked by the decode_out monitor.

Parameters:
- WIDTH, 16, instruction/PC width; only 16 supported. Bit fields below assume 16.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- enable_decode  input  1  stage enable from controller; capture/decode on a clock edge when high
- dout  input  16  instruction word from instruction memory
- npc_in  input  16  PC+1 from fetch
- IR  output  16  registered instruction
- npc_out  output  16  registered PC+1
- E_control  output  6  {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}
- W_control  output  2  writeback select
- Mem_Control  output  1  memory-indirect select
- decode_valid  output  1  high once at least one instruction has been decoded since reset

Behaviour:
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset (synchronous, active-high, dominates enable): IR, npc_out, E_control, W_control, Mem_Control and decode_valid all become 0 at the next rising edge.
- Enable high at an edge: outputs update with the decode of dout/npc_in sampled at that edge. Latency is 1 cycle.
- Enable low: all outputs hold their previous values (stall). Back-to-back enables decode a new instruction every cycle.
- decode_valid: set to 1 on the first enabled edge after reset; stays 1 until the next reset.
- Opcode is dout[15:12]. Every field not listed for an opcode is 0.
- alu_control: ADD(0001)=00, AND(0101)=01, NOT(1001)=10.
- op2select, ADD/AND: 1 (register source) when dout[5]=0; 0 (imm5) when dout[5]=1. NOT: 0.
- pcselect1: 01 (offset9) for BR(0000), LD(0010), LDI(1010), ST(0011), STI(1011), LEA(1110).
- pcselect1: 10 (offset6) for LDR(0110), STR(0111).
- pcselect1: 11 (zero offset) for JMP(1100).
- pcselect2: 1 (npc base) for BR, LD, LDI, ST, STI, LEA. 0 (register base) for LDR, STR, JMP.
- W_control: 00 ALU result (ADD/AND/NOT and all others), 01 PC-relative address (LEA), 10 memory data (LD, LDR, LDI).
- Mem_Control: 1 for LDI and STI, 0 otherwise.
- Unsupported opcodes (JSR 0100, RTI 1000, reserved 1101, TRAP 1111):
  - IR and npc_out are still captured.
  - E_control, W_control and Mem_Control are 0.
  - decode_valid is still set.
- IR captures dout unchanged, including bits that are don't-care for that opcode.
- Reset asserted together with enable: reset wins; the instruction is dropped.
- Enable asserted on the first cycle after reset deasserts: that instruction is decoded normally.

Test Plan:
- Reset: reset=1, enable_decode=1, dout=16'h1042, npc_in=16'h3001 for 2 cycles -> all outputs 0, decode_valid=0.
- ALU ops, npc_in=16'h3001, enable each cycle:
  - 16'h1042 (ADD R0,R1,R2) -> IR=1042, npc_out=3001, E_control=6'b000001, W_control=00, Mem_Control=0, decode_valid=1.
  - 16'h1261 (ADD R1,R1,#1) -> E_control=6'b000000.
  - 16'h5042 (AND) -> E_control=6'b010001.
  - 16'h927F (NOT) -> E_control=6'b100000.
- Memory/PC ops, back-to-back enables:
  - 16'h6042 (LDR) -> E_control=6'b001000, W_control=10, Mem_Control=0.
  - 16'hA005 (LDI) -> E_control=6'b000110, W_control=10, Mem_Control=1.
  - 16'hE005 (LEA) -> E_control=6'b000110, W_control=01.
  - 16'hC1C0 (JMP) -> E_control=6'b001100, W_control=00.
- Stall: decode 16'h1042, then enable_decode=0 for 3 cycles while dout=16'hA005 -> outputs hold the 1042 decode. Re-enable -> next edge shows the LDI decode.
- Unsupported opcode: dout=16'hD123 -> IR=D123, E_control=0, W_control=0, Mem_Control=0.
- Reset mid-stream: with the LDI decode present, reset=1 together with enable=1 -> all outputs and decode_valid cleared next edge. The first enabled edge after reset re-sets decode_valid.

Source files
------------

// File: rtl/lc3_decode_stage.sv
// LC-3 decode pipeline stage: registers the fetched instruction and next-PC and
// turns the opcode into execute, writeback and memory control fields.
module lc3_decode_stage #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable_decode,
  input  logic [WIDTH-1:0] dout,
  input  logic [WIDTH-1:0] npc_in,
  output logic [WIDTH-1:0] IR,
  output logic [WIDTH-1:0] npc_out,
  output logic [5:0]       E_control,
  output logic [1:0]       W_control,
  output logic             Mem_Control,
  output logic             decode_valid
);

  // Handshake: enable_decode is a one-sided qualifier. An edge with it high
  // consumes dout/npc_in; with it low every output holds (stall). No backpressure.

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  logic [3:0] opcode;
  logic [1:0] alu_control;
  logic [1:0] pcselect1;
  logic       pcselect2;
  logic       op2select;
  logic [1:0] w_next;
  logic       mem_next;

  assign opcode = dout[15:12];

  always_comb begin
    alu_control = 2'b00;
    pcselect1   = 2'b00;
    pcselect2   = 1'b0;
    op2select   = 1'b0;
    w_next      = 2'b00;
    mem_next    = 1'b0;
    unique case (opcode)
      OP_ADD: op2select = ~dout[5];
      OP_AND: begin
        alu_control = 2'b01;
        op2select   = ~dout[5];
      end
      OP_NOT: alu_control = 2'b10;
      OP_BR, OP_ST: begin
        pcselect1 = 2'b01;
        pcselect2 = 1'b1;
      end
      OP_LD: begin
        pcselect1 = 2'b01;
        pcselect2 = 1'b1;
        w_next    = 2'b10;
      end
      OP_LDI: begin
        pcselect1 = 2'b01;
        pcselect2 = 1'b1;
        w_next    = 2'b10;
        mem_next  = 1'b1;
      end
      OP_STI: begin
        pcselect1 = 2'b01;
        pcselect2 = 1'b1;
        mem_next  = 1'b1;
      end
      OP_LEA: begin
        pcselect1 = 2'b01;
        pcselect2 = 1'b1;
        w_next    = 2'b01;
      end
      OP_LDR: begin
        pcselect1 = 2'b10;
        w_next    = 2'b10;
      end
      OP_STR: pcselect1 = 2'b10;
      OP_JMP: pcselect1 = 2'b11;
      // JSR, RTI, reserved and TRAP leave every control field at zero.
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      IR           <= '0;
      npc_out      <= '0;
      E_control    <= '0;
      W_control    <= '0;
      Mem_Control  <= 1'b0;
      decode_valid <= 1'b0;
    end else if (enable_decode) begin
      IR           <= dout;
      npc_out      <= npc_in;
      E_control    <= {alu_control, pcselect1, pcselect2, op2select};
      W_control    <= w_next;
      Mem_Control  <= mem_next;
      decode_valid <= 1'b1;
    end
  end

endmodule
